// File: rtl/mem_bist_pkg.sv
// Shared types and March C- element table for the memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    E0,
    E1,
    E2,
    E3,
    E4,
    E5
  } elem_e;

  // down: walk WORDS-1..0; rd/wr: element reads and/or writes; rval/wval: bit replicated over the word
  typedef struct packed {
    logic down;
    logic rd;
    logic wr;
    logic rval;
    logic wval;
  } elem_cfg_t;

  localparam elem_cfg_t CFG_E0 = '{down: 1'b0, rd: 1'b0, wr: 1'b1, rval: 1'b0, wval: 1'b0};
  localparam elem_cfg_t CFG_E1 = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rval: 1'b0, wval: 1'b1};
  localparam elem_cfg_t CFG_E2 = '{down: 1'b0, rd: 1'b1, wr: 1'b1, rval: 1'b1, wval: 1'b0};
  localparam elem_cfg_t CFG_E3 = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rval: 1'b0, wval: 1'b1};
  localparam elem_cfg_t CFG_E4 = '{down: 1'b1, rd: 1'b1, wr: 1'b1, rval: 1'b1, wval: 1'b0};
  localparam elem_cfg_t CFG_E5 = '{down: 1'b0, rd: 1'b1, wr: 1'b0, rval: 1'b0, wval: 1'b0};

  function automatic elem_cfg_t elem_cfg(input elem_e e);
    case (e)
      E0:      return CFG_E0;
      E1:      return CFG_E1;
      E2:      return CFG_E2;
      E3:      return CFG_E3;
      E4:      return CFG_E4;
      default: return CFG_E5;
    endcase
  endfunction

  function automatic elem_e elem_next(input elem_e e);
    case (e)
      E0:      return E1;
      E1:      return E2;
      E2:      return E3;
      E3:      return E4;
      default: return E5;
    endcase
  endfunction

endpackage

// File: rtl/mem_march_bist.sv
// March C- BIST controller for a 1-cycle read-first single-port RAM.
// state | meaning: IDLE wait start | RUN issue one op/cycle | FLUSH compare last read | DONE one-cycle done
module mem_march_bist
  import mem_bist_pkg::*;
#(
  parameter int DW           = 8,
  parameter int WORDS        = 256,
  parameter bit STOP_ON_FAIL = 1'b1,
  localparam int AW          = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_qout
);

  localparam logic [AW-1:0] ADDR_MAX = AW'(WORDS - 1);

  state_e          state, state_nxt;
  elem_e           elem;
  logic [AW-1:0]   addr;
  logic            phase;
  elem_cfg_t       cfg, cfg_nxt;
  logic            rd_vld;
  logic [DW-1:0]   rd_exp;
  logic [AW-1:0]   rd_addr;
  logic            addr_last, issue_rd, step_done, last_op, mismatch, accept;

  always_comb begin
    cfg       = elem_cfg(elem);
    cfg_nxt   = elem_cfg(elem_next(elem));
    addr_last = cfg.down ? (addr == '0) : (addr == ADDR_MAX);
    issue_rd  = (state == RUN) && cfg.rd && !phase;
    // An address is finished after its write in r,w elements, or after its single op otherwise
    step_done = !(cfg.rd && cfg.wr) || phase;
    last_op   = (elem == E5) && addr_last;
    mismatch  = rd_vld && (mem_qout != rd_exp);
    accept    = (state == IDLE) && start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy     = 1'b1;
        mem_addr = addr;
        mem_we   = !issue_rd;
        mem_din  = issue_rd ? '0 : {DW{cfg.wval}};
        if (mismatch && STOP_ON_FAIL) state_nxt = DONE;
        else if (last_op)             state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem      <= E0;
      addr      <= '0;
      phase     <= 1'b0;
      rd_vld    <= 1'b0;
      rd_exp    <= '0;
      rd_addr   <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      rd_vld <= issue_rd;
      if (issue_rd) begin
        rd_exp  <= {DW{cfg.rval}};
        rd_addr <= addr;
      end
      if (accept) begin
        elem      <= E0;
        addr      <= '0;
        phase     <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else begin
        if (state == RUN) begin
          if (!step_done) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (addr_last) begin
              elem <= elem_next(elem);
              addr <= cfg_nxt.down ? ADDR_MAX : '0;
            end else begin
              addr <= cfg.down ? addr - AW'(1) : addr + AW'(1);
            end
          end
        end
        if (mismatch && !fail) begin
          fail      <= 1'b1;
          fail_addr <= rd_addr;
          fail_exp  <= rd_exp;
          fail_got  <= mem_qout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench: two BIST instances (abort / run-to-end) each driving a faultable RAM model.
module tb_mem_march_bist;

  localparam int DW    = 8;
  localparam int WORDS = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;

  logic          busy_a, done_a, fail_a, mem_we_a;
  logic [AW-1:0] fail_addr_a, mem_addr_a;
  logic [DW-1:0] fail_exp_a, fail_got_a, mem_din_a, mem_qout_a;

  logic          busy_b, done_b, fail_b, mem_we_b;
  logic [AW-1:0] fail_addr_b, mem_addr_b;
  logic [DW-1:0] fail_exp_b, fail_got_b, mem_din_b, mem_qout_b;

  logic [DW-1:0] ram_a [WORDS];
  logic [DW-1:0] ram_b [WORDS];
  int fault_a = 0;
  int fault_b = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;

  mem_march_bist #(.DW(DW), .WORDS(WORDS), .STOP_ON_FAIL(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .fail(fail_a), .fail_addr(fail_addr_a), .fail_exp(fail_exp_a), .fail_got(fail_got_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_din(mem_din_a), .mem_qout(mem_qout_a)
  );

  mem_march_bist #(.DW(DW), .WORDS(WORDS), .STOP_ON_FAIL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .fail(fail_b), .fail_addr(fail_addr_b), .fail_exp(fail_exp_b), .fail_got(fail_got_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_din(mem_din_b), .mem_qout(mem_qout_b)
  );

  // Fault 1: addr 5 bit 0 stuck-at-1; fault 2: addr 15 bit 7 stuck-at-0; fault 3: write to 3 flips 4
  function automatic logic [DW-1:0] faulty_read(input int f, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f == 1 && a == 4'd5)  r[0] = 1'b1;
    if (f == 2 && a == 4'd15) r[7] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    mem_qout_a <= faulty_read(fault_a, mem_addr_a, ram_a[mem_addr_a]);
    if (mem_we_a) begin
      ram_a[mem_addr_a] <= mem_din_a;
      if (fault_a == 3 && mem_addr_a == 4'd3) ram_a[4] <= ~ram_a[4];
    end
  end

  always @(posedge clk) begin
    mem_qout_b <= faulty_read(fault_b, mem_addr_b, ram_b[mem_addr_b]);
    if (mem_we_b) begin
      ram_b[mem_addr_b] <= mem_din_b;
      if (fault_b == 3 && mem_addr_b == 4'd3) ram_b[4] <= ~ram_b[4];
    end
  end

  always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Starts sampling in cycle 1 (first cycle after the start edge)
  task automatic watch(input bit b, output int busy_cnt, output int done_cyc, output logic done_we);
    busy_cnt = 0;
    done_cyc = -1;
    done_we  = 1'bx;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (b ? busy_b : busy_a) busy_cnt++;
      if (b ? done_b : done_a) begin
        done_cyc = cyc;
        done_we  = b ? mem_we_b : mem_we_a;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc, dc0;
    logic dw;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busy_a, done_a, fail_a, fail_addr_a, fail_exp_a, fail_got_a,
                              mem_addr_a, mem_we_a, mem_din_a}, 64'd0);
    check("reset_outputs_b", {busy_b, done_b, fail_b, fail_addr_b, fail_exp_b, fail_got_b,
                              mem_addr_b, mem_we_b, mem_din_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free pass
    pulse(1'b0);
    watch(1'b0, bc, dc, dw);
    check("clean_busy_cycles", bc, 161);
    check("clean_done_cycle", dc, 162);
    check("clean_fail", fail_a, 1'b0);
    check("clean_we_at_done", dw, 1'b0);

    // Stuck-at-1, abort: E1 read of addr 5 in cycle 27, mismatch seen in 28, done in 29
    fault_a = 1;
    pulse(1'b0);
    watch(1'b0, bc, dc, dw);
    check("sa1_done_cycle", dc, 29);
    check("sa1_busy_cycles", bc, 28);
    check("sa1_fail", fail_a, 1'b1);
    check("sa1_fail_addr", fail_addr_a, 4'd5);
    check("sa1_fail_exp", fail_exp_a, 8'h00);
    check("sa1_fail_got", fail_got_a, 8'h01);
    check("sa1_we_at_done", dw, 1'b0);

    // Stuck-at-0, run to completion: first capture is the E2 read of addr 15
    fault_b = 2;
    pulse(1'b1);
    watch(1'b1, bc, dc, dw);
    check("sa0_done_cycle", dc, 162);
    check("sa0_fail", fail_b, 1'b1);
    check("sa0_fail_addr", fail_addr_b, 4'd15);
    check("sa0_fail_exp", fail_exp_b, 8'hFF);
    check("sa0_fail_got", fail_got_b, 8'h7F);

    // Coupling 3->4: E1 read of addr 4 in cycle 25 returns FF, done in 27
    fault_a = 3;
    pulse(1'b0);
    watch(1'b0, bc, dc, dw);
    check("cf_done_cycle", dc, 27);
    check("cf_fail", fail_a, 1'b1);
    check("cf_fail_addr", fail_addr_a, 4'd4);
    check("cf_fail_got", fail_got_a, 8'hFF);
    check("cf_start_clears_prev", fail_exp_a, 8'h00);

    // Restart ignored mid-test, then reset mid-test
    fault_a = 0;
    pulse(1'b0);
    repeat (49) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    check("ignore_start_addr", mem_addr_a, 4'd5);
    check("ignore_start_we", mem_we_a, 1'b1);
    check("ignore_start_din", mem_din_a, 8'h00);
    dc0 = done_cnt_a;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy_a, done_a, fail_a, fail_addr_a, fail_exp_a, fail_got_a,
                               mem_addr_a, mem_we_a, mem_din_a}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_done", done_cnt_a - dc0, 0);
    check("midreset_idle_busy", busy_a, 1'b0);
    pulse(1'b0);
    watch(1'b0, bc, dc, dw);
    check("after_reset_done_cycle", dc, 162);
    check("after_reset_fail", fail_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_march_bist.md
MEM_MARCH_BIST -- requirements
Module: mem_march_bist

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning RAM data width.
REQ-002 The block SHALL have parameter WORDS, default 256, meaning RAM depth; address width is $clog2(WORDS).
REQ-003 The block SHALL have parameter STOP_ON_FAIL, default 1, meaning abort on the first mismatch when 1 and run to completion when 0.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a test.
REQ-007 The block SHALL have port busy, output, 1 bit: test in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at test end.
REQ-009 The block SHALL have port fail, output, 1 bit: sticky mismatch flag, valid from done until the next accepted start.
REQ-010 The block SHALL have ports fail_addr (AW bits), fail_exp (DW bits) and fail_got (DW bits), all outputs: address, expected word and read word of the first mismatch.
REQ-011 The block SHALL have port mem_addr, output, AW bits: RAM address.
REQ-012 The block SHALL have port mem_we, output, 1 bit: RAM write enable.
REQ-013 The block SHALL have port mem_din, output, DW bits: RAM write data.
REQ-014 The block SHALL have port mem_qout, input, DW bits: RAM read data, registered with 1-cycle read latency (read-first single-port RAM).

Function
REQ-015 The block SHALL run March C- with D0 = all-zeros and D1 = all-ones words: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-016 The block SHALL issue exactly one RAM operation per cycle; in each r,w element the read of address a SHALL occupy one cycle and the write of the same a the next cycle.
REQ-017 The up direction SHALL run addresses 0..WORDS-1 and the down direction WORDS-1..0, with no wrap past either end.
REQ-018 The block SHALL use states IDLE, RUN, FLUSH and DONE: IDLE->RUN on start; RUN->FLUSH after the last E5 read; FLUSH->DONE; DONE->IDLE unconditionally.
REQ-019 start SHALL be sampled only in IDLE; start in RUN, FLUSH or DONE SHALL be ignored.
REQ-020 The block SHALL compare mem_qout against the expected value one cycle after each read issue, using a 1-deep valid/expected/address pipeline.
REQ-021 busy SHALL be 1 in RUN and FLUSH and 0 otherwise.
REQ-022 done SHALL be 1 only in DONE; with no abort, done SHALL occur in cycle 10*WORDS+2 after the start edge.
REQ-023 mem_we SHALL be 0 in IDLE, FLUSH and DONE; mem_addr and mem_din SHALL be 0 when idle.
REQ-024 On the first mismatch, the block SHALL set fail and capture fail_addr, fail_exp and fail_got; later mismatches SHALL NOT overwrite the capture.
REQ-025 With STOP_ON_FAIL=1, a detected mismatch SHALL force the next state to DONE and mem_we=0 from the next cycle.
REQ-026 An accepted start SHALL clear fail, fail_addr, fail_exp and fail_got.
REQ-027 A mismatch on the final E5 read SHALL be detected in FLUSH and reported at the same done.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, with busy, done, fail, fail_addr, fail_exp, fail_got, mem_addr, mem_we and mem_din all 0, and the compare pipeline cleared.
REQ-029 Reset mid-test SHALL abort with no done pulse; RAM contents are then undefined and not restored.

Structure
REQ-030 The package mem_bist_pkg SHALL hold the state enum, the march-element enum (E0..E5) and per-element direction and read/write-value constants.
REQ-031 No sub-module SHALL be used; the address counter, element sequencer and comparator SHALL be inline.

Verification (DW=8, WORDS=16, against a 1-cycle read-first single-port RAM)
REQ-032 Fault-free RAM, start pulse -> busy for 161 cycles; done in cycle 162; fail=0.
REQ-033 Bit 0 of address 5 stuck-at-1, STOP_ON_FAIL=1 -> fail=1, fail_addr=5, fail_exp=0x00, fail_got=0x01; done 2 cycles after the E1 read of address 5.
REQ-034 Bit 7 of address 15 stuck-at-0, STOP_ON_FAIL=0 -> done in cycle 162, fail_addr=15, fail_exp=0xFF, fail_got=0x7F; first capture retained.
REQ-035 Coupling fault (write address 3 flips address 4) -> fail=1, fail_addr=4.
REQ-036 start repeated in cycle 50 of a test; rst_n low in cycle 80 -> the second start is ignored; after reset all outputs are 0 with no done; a new start then passes.
